// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_pkg
//  Description : Shared constants, MMIO decode enum and lane-rotation helpers
//                for the data-memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
package data_mem_responder_pkg;

  // Default base of the 16-byte UART MMIO page
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'haaaaa000;

  // Word offsets within the MMIO page (mem_addr[3:2])
  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_CTRL   = 2'd1;
  localparam logic [1:0] OFF_TXDATA = 2'd2;
  localparam logic [1:0] OFF_RXDATA = 2'd3;

  // STATUS register bit positions
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_RX_OVERRUN = 3;

  typedef enum logic [2:0] {
    SEL_RAM    = 3'd0,
    SEL_STATUS = 3'd1,
    SEL_CTRL   = 3'd2,
    SEL_TX     = 3'd3,
    SEL_RX     = 3'd4
  } mmio_sel_e;

  // Rotate a word left by sh bits (sh in 0..31); shifting by 32 yields zero
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] sh);
    logic [5:0] inv;
    inv = 6'd32 - {1'b0, sh};
    return (x << sh) | (x >> inv);
  endfunction

  // Rotate a word right by sh bits (sh in 0..31)
  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] sh);
    logic [5:0] inv;
    inv = 6'd32 - {1'b0, sh};
    return (x >> sh) | (x << inv);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with extra-bit wrap pointers and a
//                combinational head output.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer and storage update; storage is cleared so the head reads zero after reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i && !full_o) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : MEM-stage data responder: byte-lane data RAM plus a UART
//                MMIO page with TX FIFO back-pressure and an RX holding reg.
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_wea_i,
  input  logic        mem_rea_i,
  input  logic [3:0]  mem_en_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_din_i,
  output logic [31:0] mem_dout_o,
  output logic        mem_hold_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i
);

  localparam int AW = $clog2(RAM_WORDS);

  mmio_sel_e   sel;
  logic [4:0]  sh;
  logic [AW-1:0] ram_idx;
  logic [31:0] ram_wdata;
  logic [31:0] mem_dout_q, mem_dout_d;
  logic [31:0] ram_q [RAM_WORDS];
  logic        tx_en_q;
  logic [7:0]  rx_byte_q;
  logic        rx_valid_q;
  logic        rx_overrun_q;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic        acc_ok, tx_push, tx_pop, rd_status, rd_rx;

  assign sh        = {mem_addr_i[1:0], 3'b000};
  assign ram_idx   = mem_addr_i[AW+1:2];
  assign ram_wdata = rotl32(mem_din_i, sh);

  // Address decode: the MMIO page is fully decoded on word offset
  always_comb begin
    sel = SEL_RAM;
    if (mem_addr_i[31:4] == MMIO_BASE[31:4]) begin
      case (mem_addr_i[3:2])
        OFF_STATUS: sel = SEL_STATUS;
        OFF_CTRL:   sel = SEL_CTRL;
        OFF_TXDATA: sel = SEL_TX;
        default:    sel = SEL_RX;
      endcase
    end
  end

  // Stall only a TX write that finds the FIFO full; a same-cycle pop does not free it
  assign mem_hold_o = mem_wea_i && (sel == SEL_TX) && fifo_full;
  assign acc_ok     = !mem_hold_o;
  assign tx_push    = mem_wea_i && (sel == SEL_TX) && !fifo_full;
  assign tx_valid_o = tx_en_q && !fifo_empty;
  assign tx_pop     = tx_valid_o && tx_ready_i;
  assign tx_data_o  = fifo_head;
  assign rd_status  = mem_rea_i && acc_ok && (sel == SEL_STATUS);
  assign rd_rx      = mem_rea_i && acc_ok && (sel == SEL_RX);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_push),
    .data_i  (mem_din_i[7:0]),
    .pop_i   (tx_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // Read-data mux; RAM words are rotated back to LSB-justified form
  always_comb begin
    mem_dout_d = mem_dout_q;
    if (mem_rea_i && acc_ok) begin
      case (sel)
        SEL_STATUS: begin
          mem_dout_d = '0;
          mem_dout_d[ST_TX_FULL]    = fifo_full;
          mem_dout_d[ST_TX_EMPTY]   = fifo_empty;
          mem_dout_d[ST_RX_VALID]   = rx_valid_q;
          mem_dout_d[ST_RX_OVERRUN] = rx_overrun_q;
        end
        SEL_CTRL: mem_dout_d = {31'b0, tx_en_q};
        SEL_TX:   mem_dout_d = '0;
        SEL_RX:   mem_dout_d = {24'b0, rx_byte_q};
        default:  mem_dout_d = rotr32(ram_q[ram_idx], sh);
      endcase
    end
  end

  // Byte-lane RAM write; read-first ordering falls out of non-blocking update
  always_ff @(posedge clk_i) begin
    if (mem_wea_i && acc_ok && (sel == SEL_RAM)) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_en_i[b]) ram_q[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end

  // Registered load data, control bit and RX holding register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_dout_q   <= '0;
      tx_en_q      <= 1'b0;
      rx_byte_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      mem_dout_q <= mem_dout_d;
      if (mem_wea_i && (sel == SEL_CTRL)) tx_en_q <= mem_din_i[0];
      if (rx_valid_i) begin
        rx_byte_q  <= rx_data_i;
        rx_valid_q <= 1'b1;
      end else if (rd_rx) begin
        rx_valid_q <= 1'b0;
      end
      if (rx_valid_i && rx_valid_q) rx_overrun_q <= 1'b1;
      else if (rd_status)           rx_overrun_q <= 1'b0;
    end
  end

  assign mem_dout_o = mem_dout_q;

endmodule
`default_nettype wire
